xbus_gpio_csr: RTL
==================

// Module: xbus_gpio_csr
// PURPOSE
//  Parametrised GPIO CSR slave on the 32-bit xbus (MemSplit32 split req/resp) of a sigma tile.
//  Provides output, direction, atomic set/clear, synchronised input and edge interrupts.
//  Replaces the fixed LED/SW CSR decode in the sigma top level; irq_o feeds the tile IRQ input.
// PARAMETERS
//  BASE_ADDR   32'h80000000  byte base of the 64-byte register window (64-byte aligned)
//  GPIO_WIDTH  32            number of pins, 1..32; register bits >= GPIO_WIDTH read 0, writes ignored
//  SYNC_STAGES 2             input synchroniser depth, 2..4
// PORTS
//  clk_i         in   1           clock
//  arst_n_i      in   1           reset, asynchronous, active-low
//  bus_req_i     in   1           xbus request
//  bus_we_i      in   1           1 = write, 0 = read
//  bus_addr_bi   in   32          byte address
//  bus_be_bi     in   4           byte enables (writes)
//  bus_wdata_bi  in   32          write data
//  bus_ack_o     out  1           request accepted
//  bus_resp_o    out  1           read data valid
//  bus_rdata_bo  out  32          read data
//  gpio_bi       in   GPIO_WIDTH  asynchronous pin inputs
//  gpio_bo       out  GPIO_WIDTH  output register
//  gpio_oe_bo    out  GPIO_WIDTH  output enable (1 = drive)
//  irq_o         out  1           level interrupt, registered
// BEHAVIOUR
//  Reset: gpio_bo, gpio_oe_bo, all CSRs, irq_o, bus_resp_o and bus_rdata_bo all = 0.
//  Handshake: bus_ack_o = bus_req_i (combinational, never stalls). Transfer accepted when req&ack.
//  Decode: hit when addr[31:6] == BASE_ADDR[31:6]; offset is addr[5:2]. Misses are acked and ignored.
//  Read: bus_resp_o pulses 1 cycle exactly one cycle after acceptance, for every read, including
//    misses and unmapped offsets. bus_rdata_bo is valid only with resp; unmapped -> 0; 0 when resp=0.
//  Write: no response. Byte enables apply per byte on all writable registers.
//  Map (byte offset):
//   0x00 OUT     rw  drives gpio_bo
//   0x04 IN      ro  synchronised pins
//   0x08 DIR     rw  drives gpio_oe_bo
//   0x0C SET     wo  OUT |= wdata; reads 0
//   0x10 CLR     wo  OUT &= ~wdata; reads 0
//   0x14 IRQ_EN  rw  per-pin enable
//   0x18 IRQ_CFG rw  per pin: 1 = rising edge, 0 = falling edge
//   0x1C IRQ_ST  W1C sticky edge flags
//  Outputs: gpio_bo and gpio_oe_bo change the cycle after the accepted write.
//  Input: gpio_bi passes a SYNC_STAGES flop chain (sync). IN = sync, so pin-to-IN latency is SYNC_STAGES cycles.
//  Edge detect: prev <= sync each cycle; rise = sync & ~prev, fall = ~sync & prev.
//  Priming: a counter masks edge detection for SYNC_STAGES+1 cycles after reset release.
//    No spurious IRQ for pins that are high out of reset.
//  IRQ_ST[i] sets on the configured edge regardless of IRQ_EN (EN masks only irq_o).
//  W1C on the same cycle as a new edge on that bit: set wins (flag stays 1).
//  irq_o <= |(IRQ_ST & IRQ_EN): one cycle after the flag and enable are both present.
//  Mid-operation reset: clears immediately. A read accepted in the reset cycle gets no response.
// CONFIGURATION
//  XBUS_GPIO_IRQ_EN defined: IRQ_EN, IRQ_CFG and IRQ_ST present, with edge/priming logic as above.
//  Not defined: 0x14-0x1C read 0, writes ignored, no edge/prime logic, irq_o tied 0.
// STRUCTURE
//  Package xbus_gpio_pkg: localparam byte offsets (GPIO_OUT_OFFS .. GPIO_IRQ_ST_OFFS) and a
//    typedef enum logic [3:0] for the word index.
//  Sub-module gpio_sync: (WIDTH, STAGES) flop-chain synchroniser, async active-low reset to 0.
//  Main module holds decode, CSRs, edge/priming logic and the response register.
// TESTING
//  1. Write OUT=0xA5A5_0F0F, be=4'b0011 -> gpio_bo=0x0000_0F0F next cycle; read 0x00 -> resp 1 cycle later, rdata 0x0000_0F0F.
//  2. OUT=0x0000_00F0; SET 0x0000_0003 then CLR 0x0000_0010 -> gpio_bo=0x0000_00E3; read SET -> 0.
//  3. Drive gpio_bi=0x1234_5678 -> IN reads old value at cycle SYNC_STAGES-1, 0x1234_5678 from cycle SYNC_STAGES.
//  4. IRQ_EN[3]=1, IRQ_CFG[3]=1; pulse pin3 0->1 -> IRQ_ST=0x8 and irq_o=1. W1C 0x8 -> irq_o=0.
//     Repeat with W1C coincident with a new edge -> flag stays 1.
//  5. Hold gpio_bi=0xFFFF_FFFF through reset release with all IRQ_EN=1 -> IRQ_ST stays 0, irq_o stays 0.
//  6. Read 0x80000024 and 0x90000000 -> resp with rdata 0. Write to a miss -> no state change.
//     Assert arst_n_i mid-read -> all outputs 0, no resp. Re-run 4 with XBUS_GPIO_IRQ_EN undefined -> irq_o=0.

Source files
------------

// File: rtl/xbus_gpio_csr_pkg.sv
// Register map constants and helpers shared by the xbus GPIO CSR slave.
package xbus_gpio_pkg;

  localparam logic [5:0] GPIO_OUT_OFFS     = 6'h00;
  localparam logic [5:0] GPIO_IN_OFFS      = 6'h04;
  localparam logic [5:0] GPIO_DIR_OFFS     = 6'h08;
  localparam logic [5:0] GPIO_SET_OFFS     = 6'h0C;
  localparam logic [5:0] GPIO_CLR_OFFS     = 6'h10;
  localparam logic [5:0] GPIO_IRQ_EN_OFFS  = 6'h14;
  localparam logic [5:0] GPIO_IRQ_CFG_OFFS = 6'h18;
  localparam logic [5:0] GPIO_IRQ_ST_OFFS  = 6'h1C;

  typedef enum logic [3:0] {
    GPIO_IDX_OUT     = 4'(GPIO_OUT_OFFS >> 2),
    GPIO_IDX_IN      = 4'(GPIO_IN_OFFS >> 2),
    GPIO_IDX_DIR     = 4'(GPIO_DIR_OFFS >> 2),
    GPIO_IDX_SET     = 4'(GPIO_SET_OFFS >> 2),
    GPIO_IDX_CLR     = 4'(GPIO_CLR_OFFS >> 2),
    GPIO_IDX_IRQ_EN  = 4'(GPIO_IRQ_EN_OFFS >> 2),
    GPIO_IDX_IRQ_CFG = 4'(GPIO_IRQ_CFG_OFFS >> 2),
    GPIO_IDX_IRQ_ST  = 4'(GPIO_IRQ_ST_OFFS >> 2)
  } gpio_idx_e;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/xbus_gpio_csr_if.sv
// xbus split request/response signal bundle; the CSR block is the slave.
interface xbus_gpio_csr_if;

  logic        bus_req_i;
  logic        bus_we_i;
  logic [31:0] bus_addr_bi;
  logic [3:0]  bus_be_bi;
  logic [31:0] bus_wdata_bi;
  logic        bus_ack_o;
  logic        bus_resp_o;
  logic [31:0] bus_rdata_bo;

  modport slave (
    input  bus_req_i, bus_we_i, bus_addr_bi, bus_be_bi, bus_wdata_bi,
    output bus_ack_o, bus_resp_o, bus_rdata_bo
  );

  modport master (
    output bus_req_i, bus_we_i, bus_addr_bi, bus_be_bi, bus_wdata_bi,
    input  bus_ack_o, bus_resp_o, bus_rdata_bo
  );

endinterface

// File: rtl/xbus_gpio_csr_sync.sv
// Multi-flop synchroniser for asynchronous GPIO pins; clears to 0 on reset.
module gpio_sync #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] chain_q [STAGES];
  logic [WIDTH-1:0] chain_d [STAGES];

  // Each stage takes the previous one; stage 0 samples the raw pins.
  always_comb begin
    chain_d[0] = d_i;
    for (int i = 1; i < int'(STAGES); i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  // Synchroniser flop chain.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        chain_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(STAGES); i++) begin
        chain_q[i] <= chain_d[i];
      end
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/xbus_gpio_csr.sv
// GPIO CSR slave on the 32-bit xbus: output/direction, set/clear, synced input.
// Edge interrupts (IRQ_EN/IRQ_CFG/IRQ_ST, irq_o) exist only when XBUS_GPIO_IRQ_EN is defined.
module xbus_gpio_csr
  import xbus_gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned GPIO_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  xbus_gpio_csr_if.slave        bus,
  input  logic [GPIO_WIDTH-1:0] gpio_bi,
  output logic [GPIO_WIDTH-1:0] gpio_bo,
  output logic [GPIO_WIDTH-1:0] gpio_oe_bo,
  output logic                  irq_o
);

  localparam logic [31:0] PIN_MASK = (GPIO_WIDTH >= 32) ? 32'hFFFF_FFFF
                                                         : ((32'h1 << GPIO_WIDTH) - 32'h1);

  logic [GPIO_WIDTH-1:0] sync_s;
  logic [31:0]           sync_w_s;
  logic                  hit_s;
  logic                  wr_s;
  logic                  rd_s;
  logic [3:0]            idx_s;
  logic [31:0]           wmask_s;
  logic [31:0]           wbits_s;
  logic [31:0]           rdata_mux_s;
  logic [31:0]           out_q, out_d;
  logic [31:0]           dir_q, dir_d;
  logic                  resp_q, resp_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  unused_s;

  gpio_sync #(
    .WIDTH  (GPIO_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .d_i      (gpio_bi),
    .q_o      (sync_s)
  );

  assign bus.bus_ack_o = bus.bus_req_i;
  assign unused_s      = ^bus.bus_addr_bi[1:0];

  // Address decode and byte-enable masking, limited to implemented pins.
  always_comb begin
    hit_s    = (bus.bus_addr_bi[31:6] == BASE_ADDR[31:6]);
    idx_s    = bus.bus_addr_bi[5:2];
    wr_s     = bus.bus_req_i & bus.bus_we_i & hit_s;
    rd_s     = bus.bus_req_i & ~bus.bus_we_i;
    wmask_s  = be_to_mask(bus.bus_be_bi) & PIN_MASK;
    wbits_s  = bus.bus_wdata_bi & wmask_s;
    sync_w_s = 32'h0;
    sync_w_s[GPIO_WIDTH-1:0] = sync_s;
  end

  // OUT/DIR updates, including the atomic SET/CLR aliases of OUT.
  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    if (wr_s) begin
      case (idx_s)
        GPIO_IDX_OUT: out_d = (out_q & ~wmask_s) | wbits_s;
        GPIO_IDX_DIR: dir_d = (dir_q & ~wmask_s) | wbits_s;
        GPIO_IDX_SET: out_d = out_q | wbits_s;
        GPIO_IDX_CLR: out_d = out_q & ~wbits_s;
        default: begin
          out_d = out_q;
          dir_d = dir_q;
        end
      endcase
    end else begin
      out_d = out_q;
      dir_d = dir_q;
    end
  end

`ifdef XBUS_GPIO_IRQ_EN
  localparam logic [2:0] PRIME_CYC = 3'(SYNC_STAGES + 1);

  logic [31:0] en_q, en_d;
  logic [31:0] cfg_q, cfg_d;
  logic [31:0] st_q, st_d;
  logic [31:0] prev_q, prev_d;
  logic [2:0]  prime_q, prime_d;
  logic        irq_q, irq_d;
  logic [31:0] w1c_s;
  logic [31:0] edge_s;

  // Edge flags; the prime counter hides the synchroniser filling after reset.
  always_comb begin
    en_d  = en_q;
    cfg_d = cfg_q;
    w1c_s = 32'h0;
    if (wr_s) begin
      case (idx_s)
        GPIO_IDX_IRQ_EN:  en_d  = (en_q & ~wmask_s) | wbits_s;
        GPIO_IDX_IRQ_CFG: cfg_d = (cfg_q & ~wmask_s) | wbits_s;
        GPIO_IDX_IRQ_ST:  w1c_s = wbits_s;
        default:          w1c_s = 32'h0;
      endcase
    end else begin
      w1c_s = 32'h0;
    end
    prev_d = sync_w_s;
    if (prime_q == PRIME_CYC) begin
      prime_d = prime_q;
      edge_s  = ((sync_w_s & ~prev_q & cfg_q) | (~sync_w_s & prev_q & ~cfg_q)) & PIN_MASK;
    end else begin
      prime_d = prime_q + 3'd1;
      edge_s  = 32'h0;
    end
    st_d  = (st_q & ~w1c_s) | edge_s;
    irq_d = |(st_q & en_q);
  end

  // Interrupt state registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      en_q    <= 32'h0;
      cfg_q   <= 32'h0;
      st_q    <= 32'h0;
      prev_q  <= 32'h0;
      prime_q <= 3'd0;
      irq_q   <= 1'b0;
    end else begin
      en_q    <= en_d;
      cfg_q   <= cfg_d;
      st_q    <= st_d;
      prev_q  <= prev_d;
      prime_q <= prime_d;
      irq_q   <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  // Read mux; every accepted read answers one cycle later, misses with 0.
  always_comb begin
    case (idx_s)
      GPIO_IDX_OUT:     rdata_mux_s = out_q;
      GPIO_IDX_IN:      rdata_mux_s = sync_w_s;
      GPIO_IDX_DIR:     rdata_mux_s = dir_q;
`ifdef XBUS_GPIO_IRQ_EN
      GPIO_IDX_IRQ_EN:  rdata_mux_s = en_q;
      GPIO_IDX_IRQ_CFG: rdata_mux_s = cfg_q;
      GPIO_IDX_IRQ_ST:  rdata_mux_s = st_q;
`endif
      default:          rdata_mux_s = 32'h0;
    endcase
    resp_d = rd_s;
    if (rd_s && hit_s) begin
      rdata_d = rdata_mux_s;
    end else begin
      rdata_d = 32'h0;
    end
  end

  // CSR and response registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      out_q   <= 32'h0;
      dir_q   <= 32'h0;
      resp_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  assign gpio_bo          = out_q[GPIO_WIDTH-1:0];
  assign gpio_oe_bo       = dir_q[GPIO_WIDTH-1:0];
  assign bus.bus_resp_o   = resp_q;
  assign bus.bus_rdata_bo = rdata_q;

endmodule
